cubic_res_writeback: RTL and testbench
======================================

CUBIC_RES_WRITEBACK -- requirements
Module: cubic_res_writeback

Interface
REQ-001 The block SHALL have parameter SIZE, default 8: lanes per result beat.
REQ-002 The block SHALL have parameter DATA_WID, default 16: bits per lane.
REQ-003 The block SHALL have parameter ADDR_WID, default 12: output-buffer word address width.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: packed-word FIFO entries (power of 2).
REQ-005 clock  input  1  the single clock; all state SHALL be on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tile_start  input  1  one-cycle pulse that opens a tile.
REQ-008 tile_beats  input  12  number of res_valid beats expected in the tile (≥1), sampled on tile_start.
REQ-009 base_addr  input  ADDR_WID  first write address for the tile, sampled on tile_start.
REQ-010 res_valid  input  1  result beat valid, from the pooling/accumulate stage; no backpressure.
REQ-011 res_pool  input  DATA_WID*SIZE  result beat, lane i at bits [i*DATA_WID +: DATA_WID].
REQ-012 wr_valid  output  1  output-buffer write request.
REQ-013 wr_ready  input  1  output buffer accepts the write this cycle.
REQ-014 wr_addr  output  ADDR_WID  write address.
REQ-015 wr_data  output  2*DATA_WID*SIZE  packed write word.
REQ-016 busy  output  1  tile in progress.
REQ-017 tile_done  output  1  one-cycle pulse when the tile's last word has been accepted.
REQ-018 ovf_err  output  1  sticky FIFO-overflow flag.

Function
REQ-019 The FSM SHALL have states IDLE, PACK and DRAIN; busy SHALL be 1 in PACK and DRAIN.
REQ-020 IDLE -> PACK on tile_start: latch tile_beats and base_addr, clear the beat counter, the half flag and ovf_err.
REQ-021 In IDLE and DRAIN, res_valid SHALL be ignored; in PACK and DRAIN, tile_start SHALL be ignored.
REQ-022 In PACK, an even-numbered beat (0, 2, ...) SHALL be held in a low-half register.
REQ-023 In PACK, an odd-numbered beat SHALL push {beat, held_low} into the FIFO, with the held beat in the low DATA_WID*SIZE bits.
REQ-024 The last beat (count == tile_beats-1) SHALL always push; if it is even-numbered, the upper half SHALL be zero.
REQ-025 On the last beat: PACK -> DRAIN.
REQ-026 DRAIN -> IDLE when the FIFO is empty and no write is pending; tile_done SHALL pulse for exactly one cycle on that transition.
REQ-027 wr_valid SHALL equal FIFO not-empty, and wr_data SHALL be the FIFO head.
REQ-028 A pop SHALL occur on wr_valid && wr_ready.
REQ-029 wr_addr SHALL equal base_addr for the first word of the tile and increment by 1 per pop, wrapping modulo 2^ADDR_WID.
REQ-030 Latency: a word pushed on cycle N SHALL present wr_valid on cycle N+1 when the FIFO was empty.
REQ-031 wr_valid and wr_data SHALL stay stable while wr_valid && !wr_ready.
REQ-032 A push while the FIFO is full and no pop occurs that cycle SHALL drop the word and set ovf_err until the next tile_start.
REQ-033 Push and pop in the same cycle on a full FIFO SHALL be legal and SHALL NOT set ovf_err.
REQ-034 A dropped word SHALL still consume its address slot, so later words keep their base-relative addresses.
REQ-035 tile_beats == 0 SHALL be treated as 1.

Reset
REQ-036 While rst is high, the block SHALL hold state IDLE and FIFO empty, with wr_valid, wr_addr, wr_data, busy, tile_done and ovf_err all 0.
REQ-037 Reset asserted mid-tile SHALL discard all pending words with no tile_done; the first tile_start after release SHALL start cleanly.

Structure
REQ-038 A shared package SHALL hold the default constants (SIZE, DATA_WID, ADDR_WID, FIFO_DEPTH) and the FSM state encoding.
REQ-039 The FIFO SHALL be one sub-module, wb_fifo, with parameterised width and depth, asynchronous active-high reset, and full/empty outputs.
REQ-040 Packing, addressing and the FSM SHALL reside in cubic_res_writeback.

Verification
REQ-041 tile_beats=4, base_addr=0x010, wr_ready=1, 4 consecutive beats -> writes at 0x010 and 0x011, {b1,b0} then {b3,b2}, then one tile_done pulse.
REQ-042 tile_beats=3 -> second word has upper 128 bits zero and low half = b2; tile_done follows.
REQ-043 tile_beats=12, wr_ready=0 for 20 cycles, then 1 -> 6 pushes, 4 stored, ovf_err=1; writes at base, base+1, base+2, base+3 only; tile_done still pulses.
REQ-044 base_addr=0xFFF, tile_beats=4 -> writes at 0xFFF then 0x000.
REQ-045 rst pulsed after 2 beats of an 8-beat tile -> all outputs 0, no tile_done; a following 2-beat tile completes normally.
REQ-046 wr_ready toggling every cycle, full FIFO with simultaneous push and pop -> no ovf_err, and data order is preserved.

Source files
------------

// File: rtl/cubic_res_writeback_pkg.sv
// Shared defaults and FSM encoding for the result writeback block.
package cubic_res_writeback_pkg;

  localparam int SIZE_DEF       = 8;
  localparam int DATA_WID_DEF   = 16;
  localparam int ADDR_WID_DEF   = 12;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int BEATS_WID      = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO: registered head, push accepted when not full or when popping the same cycle.
// Pop on empty and push on full-without-pop are ignored; the caller decides what a refused push means.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cubic_res_writeback.sv
// Packs result beat pairs into double-width words and writes them to the output buffer; a word pushed
// on cycle N is offered on N+1. No backpressure upstream: a full FIFO drops the word and flags ovf_err.
module cubic_res_writeback
  import cubic_res_writeback_pkg::*;
#(
  parameter int SIZE       = SIZE_DEF,
  parameter int DATA_WID   = DATA_WID_DEF,
  parameter int ADDR_WID   = ADDR_WID_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       tile_start,
  input  logic [11:0]                tile_beats,
  input  logic [ADDR_WID-1:0]        base_addr,
  input  logic                       res_valid,
  input  logic [DATA_WID*SIZE-1:0]   res_pool,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_WID-1:0]        wr_addr,
  output logic [2*DATA_WID*SIZE-1:0] wr_data,
  output logic                       busy,
  output logic                       tile_done,
  output logic                       ovf_err
);

  localparam int BW = DATA_WID * SIZE;
  localparam int WW = 2 * BW;
  localparam int FW = ADDR_WID + WW;

  wb_state_t             state;
  wb_state_t             state_nxt;
  logic [BEATS_WID-1:0]  beats_m1;
  logic [BEATS_WID-1:0]  beat_cnt;
  logic [BW-1:0]         low_q;
  logic [ADDR_WID-1:0]   push_addr;
  logic                  beat_in;
  logic                  last_beat;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [WW-1:0]         push_word;
  logic [FW-1:0]         fifo_head;

  assign beat_in   = (state == ST_PACK) && res_valid;
  assign last_beat = (beat_cnt == beats_m1);
  // Beat counter bit 0 doubles as the half flag: set means a low half is being held.
  assign push      = beat_in && (beat_cnt[0] || last_beat);
  assign push_word = beat_cnt[0] ? {res_pool, low_q} : {{BW{1'b0}}, res_pool};
  assign pop       = wr_valid && wr_ready;

  always_comb begin
    state_nxt = state;
    tile_done = 1'b0;
    case (state)
      ST_IDLE:  if (tile_start) state_nxt = ST_PACK;
      ST_PACK:  if (beat_in && last_beat) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_nxt = ST_IDLE;
          tile_done = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      beats_m1  <= '0;
      beat_cnt  <= '0;
      low_q     <= '0;
      push_addr <= '0;
      ovf_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && tile_start) begin
        beats_m1  <= (tile_beats == 12'd0) ? 12'd0 : tile_beats - 12'd1;
        beat_cnt  <= '0;
        push_addr <= base_addr;
        ovf_err   <= 1'b0;
      end
      if (beat_in) begin
        beat_cnt <= beat_cnt + 12'd1;
        if (!beat_cnt[0]) low_q <= res_pool;
      end
      // Address advances on every packed word, dropped or not, so later words keep their slots.
      if (push) begin
        push_addr <= push_addr + ADDR_WID'(1);
        if (fifo_full && !pop) ovf_err <= 1'b1;
      end
    end
  end

  wb_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (push),
    .wdata ({push_addr, push_word}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr_valid = !fifo_empty;
  assign wr_addr  = wr_valid ? fifo_head[FW-1 -: ADDR_WID] : '0;
  assign wr_data  = wr_valid ? fifo_head[WW-1:0] : '0;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_cubic_res_writeback.sv
// Scoreboard bench for cubic_res_writeback: expected words queued at push time, compared on write.
module tb_cubic_res_writeback;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [11:0]  addr;
    logic [255:0] data;
  } exp_t;

  logic         clock = 1'b0;
  logic         rst;
  logic         tile_start;
  logic [11:0]  tile_beats;
  logic [11:0]  base_addr;
  logic         res_valid;
  logic [127:0] res_pool;
  logic         wr_valid;
  logic         wr_ready;
  logic [11:0]  wr_addr;
  logic [255:0] wr_data;
  logic         busy;
  logic         tile_done;
  logic         ovf_err;

  exp_t q[$];
  exp_t pw;
  bit   push_pend;
  bit   exp_ovf;
  bit   tog;
  int   stall_cnt;
  int   done_cnt;
  int   n_checks;
  int   n_err;

  cubic_res_writeback dut (
    .clock      (clock),
    .rst        (rst),
    .tile_start (tile_start),
    .tile_beats (tile_beats),
    .base_addr  (base_addr),
    .res_valid  (res_valid),
    .res_pool   (res_pool),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .tile_done  (tile_done),
    .ovf_err    (ovf_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [299:0] act, input logic [299:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_ready(input int stall, input bit toggle);
    stall_cnt = stall;
    tog       = toggle;
    wr_ready  = (stall > 0) ? 1'b0 : 1'b1;
  endtask

  // One clock: observe and model at the falling edge, then step past the rising edge.
  task automatic cycle();
    bit exp_v;
    @(negedge clock);
    if (!rst) begin
      exp_v = (q.size() != 0);
      check("wr_valid", wr_valid, exp_v);
      if (tile_done) begin
        done_cnt++;
        check("done_with_pending", q.size(), 0);
      end
      if (exp_v) begin
        check("wr_addr", wr_addr, q[0].addr);
        check("wr_data", wr_data, q[0].data);
        if (wr_ready) void'(q.pop_front());
      end
      if (push_pend) begin
        if (q.size() < DEPTH) q.push_back(pw);
        else exp_ovf = 1'b1;
      end
    end
    push_pend = 1'b0;
    @(posedge clock);
    #1;
    if (stall_cnt > 0) begin
      stall_cnt--;
      wr_ready = 1'b0;
    end else if (tog) begin
      wr_ready = ~wr_ready;
    end else begin
      wr_ready = 1'b1;
    end
  endtask

  task automatic run_tile(input int nb, input logic [11:0] base, input bit noise);
    int           eff;
    int           d0;
    logic [127:0] b;
    logic [127:0] low;
    logic [11:0]  a;
    eff        = (nb == 0) ? 1 : nb;
    a          = base;
    low        = '0;
    d0         = done_cnt;
    exp_ovf    = 1'b0;
    tile_beats = 12'(nb);
    base_addr  = base;
    tile_start = 1'b1;
    cycle();
    tile_start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    for (int k = 0; k < eff; k++) begin
      b         = rnd128();
      res_valid = 1'b1;
      res_pool  = b;
      if (noise && k == 1) begin
        tile_start = 1'b1;
        tile_beats = 12'd2;
        base_addr  = 12'h555;
      end
      if (k % 2 == 0) low = b;
      if (k % 2 == 1) begin
        push_pend = 1'b1;
        pw        = {a, b, low};
        a         = a + 12'd1;
      end else if (k == eff - 1) begin
        push_pend = 1'b1;
        pw        = {a, 128'd0, b};
        a         = a + 12'd1;
      end
      cycle();
      tile_start = 1'b0;
      tile_beats = 12'(nb);
      base_addr  = base;
    end
    res_valid = noise;
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      res_pool = rnd128();
      cycle();
    end
    res_valid = 1'b0;
    check("tile_done_seen", done_cnt - d0, 1);
    repeat (3) cycle();
    check("tile_done_once", done_cnt - d0, 1);
    check("busy_idle", busy, 1'b0);
    check("ovf_err", ovf_err, exp_ovf);
    check("sb_empty", q.size(), 0);
  endtask

  initial begin
    int d0;
    rst        = 1'b1;
    tile_start = 1'b0;
    tile_beats = '0;
    base_addr  = '0;
    res_valid  = 1'b0;
    res_pool   = '0;
    push_pend  = 1'b0;
    exp_ovf    = 1'b0;
    done_cnt   = 0;
    n_checks   = 0;
    n_err      = 0;
    set_ready(0, 1'b0);
    repeat (3) cycle();
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 12'h000);
    check("rst_wr_data", wr_data, 256'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_tile_done", tile_done, 1'b0);
    check("rst_ovf_err", ovf_err, 1'b0);
    rst = 1'b0;
    cycle();

    // Beats while idle must not produce writes.
    res_valid = 1'b1;
    repeat (3) begin
      res_pool = rnd128();
      cycle();
    end
    res_valid = 1'b0;

    set_ready(0, 1'b0);
    run_tile(4, 12'h010, 1'b0);
    run_tile(3, 12'h020, 1'b0);
    run_tile(0, 12'h030, 1'b0);
    run_tile(5, 12'h040, 1'b1);

    // Stalled output buffer: two of six words are dropped.
    set_ready(19, 1'b0);
    run_tile(12, 12'h100, 1'b1);

    set_ready(0, 1'b0);
    run_tile(4, 12'hFFF, 1'b0);

    // Fill, then toggle ready so pushes meet pops on a full FIFO.
    set_ready(9, 1'b1);
    run_tile(16, 12'h200, 1'b0);
    set_ready(0, 1'b1);
    run_tile(7, 12'h300, 1'b0);

    // Reset in the middle of a tile.
    set_ready(0, 1'b0);
    d0         = done_cnt;
    tile_beats = 12'd8;
    base_addr  = 12'h400;
    tile_start = 1'b1;
    cycle();
    tile_start = 1'b0;
    res_valid  = 1'b1;
    res_pool   = rnd128();
    cycle();
    res_pool   = rnd128();
    cycle();
    res_valid  = 1'b0;
    rst        = 1'b1;
    #1;
    check("mid_rst_wr_valid", wr_valid, 1'b0);
    check("mid_rst_wr_addr", wr_addr, 12'h000);
    check("mid_rst_wr_data", wr_data, 256'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_tile_done", tile_done, 1'b0);
    check("mid_rst_ovf_err", ovf_err, 1'b0);
    q.delete();
    push_pend = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (2) cycle();
    check("mid_rst_no_done", done_cnt - d0, 0);
    run_tile(2, 12'h500, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
